// File: rtl/config_frame_loader_pkg.sv
// rtl/config_frame_loader_pkg.sv - shared states and stream constants for config_frame_loader
// The CHK state exists only when CONFIG_FRAME_LOADER_CRC_EN is defined.
package config_frame_loader_pkg;
  localparam logic [31:0] SYNC_WORD = 32'hFAB0FAB1;
  localparam logic [7:0]  CMD_WRITE = 8'h01;
  localparam logic [7:0]  CMD_END   = 8'h00;

  typedef enum logic [3:0] {
    SYNC, CMD, COL, FRM, DATA, SETUP, STROBE, HOLD
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    , CHK
`endif
  } state_e;
endpackage

// File: rtl/config_sync_detect.sv
// rtl/config_sync_detect.sv - 32-bit MSB-first shift register with sync word compare
// match looks at the value being shifted in, so no byte after the sync word is lost.
module config_sync_detect
  import config_frame_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic [7:0] byte_in,
  output logic       match
);
  logic [31:0] sync_q, sync_d;

  always_comb begin
    sync_d = sync_q;
    if (shift_en) sync_d = {sync_q[23:0], byte_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign match = shift_en && (sync_d == SYNC_WORD);
endmodule

// File: rtl/config_frame_loader.sv
// rtl/config_frame_loader.sv - byte-stream configuration frame loader with column/frame strobes
// Optional trailing XOR check byte: define CONFIG_FRAME_LOADER_CRC_EN.
module config_frame_loader
  import config_frame_loader_pkg::*;
#(
  parameter int NUM_COLUMNS    = 16,
  parameter int FRAMES_PER_COL = 20,
  parameter int FRAME_BITS     = 32
) (
  input  logic                      UserCLK,
  input  logic                      resetn,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [FRAME_BITS-1:0]     FrameData,
  output logic [NUM_COLUMNS-1:0]    ColSelect,
  output logic [FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  input  logic                      err_clr
);
  localparam int BYTES = FRAME_BITS / 8;
  localparam int CW    = $clog2(BYTES + 1);

  state_e                state_q, state_d;
  logic [7:0]            col_q, col_d, frm_q, frm_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  accept, sync_match, col_ok, idx_ok, last_byte, fault, col_active;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
  logic [7:0]            chk_q, chk_d;
`endif

  assign s_ready    = !(state_q inside {SETUP, STROBE, HOLD});
  assign accept     = s_valid && s_ready;
  assign col_ok     = 32'(col_q) < NUM_COLUMNS;
  assign idx_ok     = col_ok && (32'(frm_q) < FRAMES_PER_COL);
  assign last_byte  = (cnt_q == CW'(BYTES - 1));
  assign col_active = !(state_q inside {SYNC, CMD, COL});

  config_sync_detect u_sync (
    .clk     (UserCLK),
    .rst_n   (resetn),
    .shift_en(accept && (state_q == SYNC)),
    .byte_in (s_data),
    .match   (sync_match)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    frm_d   = frm_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fault   = 1'b0;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      SYNC: if (sync_match) state_d = CMD;
      CMD: if (accept) begin
        if (s_data == CMD_WRITE) state_d = COL;
        else begin
          state_d = SYNC;
          if (s_data == CMD_END) done_d = 1'b1;
          else                   fault  = 1'b1;
        end
      end
      COL: if (accept) begin
        col_d   = s_data;
        state_d = FRM;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
        chk_d   = s_data;
`endif
      end
      FRM: if (accept) begin
        frm_d   = s_data;
        cnt_d   = '0;
        state_d = DATA;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
        chk_d   = chk_q ^ s_data;
`endif
      end
      DATA: if (accept) begin
        data_d = (data_q << 8) | FRAME_BITS'(s_data);
        cnt_d  = cnt_q + CW'(1);
`ifdef CONFIG_FRAME_LOADER_CRC_EN
        chk_d  = chk_q ^ s_data;
        if (last_byte) state_d = CHK;
`else
        if (last_byte) begin
          if (idx_ok) state_d = SETUP;
          else begin
            fault   = 1'b1;
            state_d = CMD;
          end
        end
`endif
      end
`ifdef CONFIG_FRAME_LOADER_CRC_EN
      CHK: if (accept) begin
        if (idx_ok && (s_data == chk_q)) state_d = SETUP;
        else begin
          fault   = 1'b1;
          state_d = CMD;
        end
      end
`endif
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = CMD;
      default: state_d = SYNC;
    endcase
    // A fault in the same cycle as err_clr keeps the flag set.
    err_d = fault || (err_q && !err_clr);
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= SYNC;
      col_q   <= '0;
      frm_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      frm_q   <= frm_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign FrameData   = data_q;
  assign ColSelect   = (col_active && col_ok) ? (NUM_COLUMNS'(1) << col_q) : '0;
  assign FrameStrobe = (state_q == STROBE) ? (FRAMES_PER_COL'(1) << frm_q) : '0;
  assign busy        = (state_q != SYNC);
  assign done        = done_q;
  assign error       = err_q;
endmodule

// File: tb/tb_config_frame_loader.sv
// tb/tb_config_frame_loader.sv - table-driven self-checking bench for config_frame_loader
// Build with CONFIG_FRAME_LOADER_CRC_EN defined to also exercise the check byte.
module tb_config_frame_loader;
  logic        UserCLK = 1'b0;
  logic        resetn  = 1'b0;
  logic        s_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic        s_ready, busy, done, error;
  logic [31:0] FrameData;
  logic [15:0] ColSelect;
  logic [19:0] FrameStrobe;

  int tests = 0;
  int fails = 0;

  always #5 UserCLK = ~UserCLK;

  config_frame_loader #(.NUM_COLUMNS(16), .FRAMES_PER_COL(20), .FRAME_BITS(32)) dut (
    .UserCLK(UserCLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .ColSelect(ColSelect), .FrameStrobe(FrameStrobe),
    .busy(busy), .done(done), .error(error), .err_clr(err_clr)
  );

  // Observer: strobe count, SETUP/HOLD stability around each strobe, s_ready low run length, done pulses.
  int          strobes = 0, dones = 0, stab_bad = 0, last_run = 0, run = 0;
  logic [19:0] last_fs = '0, prev_fs = '0;
  logic [15:0] last_cs = '0, prev_cs = '0;
  logic [31:0] last_fd = '0, prev_fd = '0;
  logic        prev_rdy = 1'b1, hold_chk = 1'b0;

  always @(negedge UserCLK) begin
    if (resetn) begin
      if (hold_chk) begin
        if (FrameStrobe != 0 || s_ready || ColSelect != last_cs || FrameData != last_fd) stab_bad++;
        hold_chk = 1'b0;
      end
      if (FrameStrobe != 0) begin
        strobes++;
        last_fs = FrameStrobe;
        last_cs = ColSelect;
        last_fd = FrameData;
        if (prev_fs != 0 || prev_rdy || prev_cs != ColSelect || prev_fd != FrameData || s_ready) stab_bad++;
        hold_chk = 1'b1;
      end
      if (done) dones++;
      if (!s_ready) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end else begin
      run      = 0;
      hold_chk = 1'b0;
    end
    prev_fs  = FrameStrobe;
    prev_cs  = ColSelect;
    prev_fd  = FrameData;
    prev_rdy = s_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      tick();
    end
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h s_ready %b required 1", b, s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_sync(input bit gap);
    send_byte(8'hFA, gap);
    send_byte(8'hB0, gap);
    send_byte(8'hFA, gap);
    send_byte(8'hB1, gap);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] col, input logic [7:0] frm, input logic [31:0] data,
                           input bit gap, input bit do_sync, input bit do_end, input logic [7:0] chk_flip);
    logic [7:0] chk;
    chk = col ^ frm ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0] ^ chk_flip;
    if (do_sync) send_sync(gap);
    send_byte(8'h01, gap);
    send_byte(col, gap);
    send_byte(frm, gap);
    for (int k = 3; k >= 0; k--) send_byte(data[k*8 +: 8], gap);
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    send_byte(chk, gap);
`endif
    if (do_end) send_byte(8'h00, gap);
    tick();
    tick();
  endtask

  typedef struct {
    logic [7:0]  col;
    logic [7:0]  frm;
    logic [31:0] data;
    bit          gap;
    int          exp_strb;
    logic [19:0] exp_fs;
    logic [15:0] exp_cs;
    bit          exp_err;
  } vec_t;

  vec_t vt [7];
  int   s0, d0;

  initial begin
    vt[0] = '{8'h03, 8'h05, 32'hDEADBEEF, 1'b0, 1, 20'h00020, 16'h0008, 1'b0};
    vt[1] = '{8'h03, 8'h05, 32'hDEADBEEF, 1'b1, 1, 20'h00020, 16'h0008, 1'b0};
    vt[2] = '{8'h00, 8'h00, 32'h00000001, 1'b0, 1, 20'h00001, 16'h0001, 1'b0};
    vt[3] = '{8'h0F, 8'h13, 32'h12345678, 1'b0, 1, 20'h80000, 16'h8000, 1'b0};
    vt[4] = '{8'h10, 8'h00, 32'hCAFEF00D, 1'b0, 0, 20'h00000, 16'h0000, 1'b1};
    vt[5] = '{8'h02, 8'h14, 32'h0BADC0DE, 1'b0, 0, 20'h00000, 16'h0000, 1'b1};
    vt[6] = '{8'hFF, 8'h03, 32'h55AA55AA, 1'b1, 0, 20'h00000, 16'h0000, 1'b1};

    tick();
    tick();
    check("rst_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_outs", {FrameStrobe != 0, ColSelect != 0, FrameData != 0, done, error}, 0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      s0 = strobes;
      d0 = dones;
      last_run = 0;
      run_frame(vt[i].col, vt[i].frm, vt[i].data, vt[i].gap, 1'b1, 1'b1, 8'h00);
      check($sformatf("v%0d_strobes", i), strobes - s0, vt[i].exp_strb);
      if (vt[i].exp_strb != 0) begin
        check($sformatf("v%0d_fs", i), last_fs, vt[i].exp_fs);
        check($sformatf("v%0d_cs", i), last_cs, vt[i].exp_cs);
        check($sformatf("v%0d_fd", i), last_fd, vt[i].data);
        check($sformatf("v%0d_ready_low", i), last_run, 3);
      end
      check($sformatf("v%0d_error", i), error, vt[i].exp_err);
      check($sformatf("v%0d_done", i), dones - d0, 1);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_stable", i), stab_bad, 0);
      if (error) begin
        pulse_clr();
        check($sformatf("v%0d_err_clr", i), error, 0);
      end
    end

    // Fault coinciding with err_clr, then a valid frame while error stays sticky.
    s0 = strobes;
    send_sync(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    send_byte(8'hEF, 1'b0);
    err_clr = 1'b1;
    send_byte(8'h10 ^ 8'h00 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 1'b0);
`else
    err_clr = 1'b1;
    send_byte(8'hEF, 1'b0);
`endif
    err_clr = 1'b0;
    check("err_vs_clr", error, 1);
    check("err_cmd_busy", busy, 1);
    run_frame(8'h03, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 8'h00);
    check("after_err_strobes", strobes - s0, 1);
    check("after_err_fs", last_fs, 20'h00020);
    check("err_sticky", error, 1);
    pulse_clr();
    check("err_cleared", error, 0);

    // Illegal command, then overlapping sync pattern.
    send_sync(1'b0);
    send_byte(8'h7F, 1'b0);
    check("badcmd_error", error, 1);
    check("badcmd_busy", busy, 0);
    send_byte(8'hFA, 1'b0);
    send_byte(8'hFA, 1'b0);
    send_byte(8'hB0, 1'b0);
    send_byte(8'hFA, 1'b0);
    check("overlap_not_yet", busy, 0);
    send_byte(8'hB1, 1'b0);
    check("overlap_cmd", busy, 1);

    // Reset while DATA byte 2 is on the bus.
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hDE, 1'b0);
    s_data  = 8'hAD;
    s_valid = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_outs", {FrameStrobe != 0, ColSelect != 0, FrameData != 0, done, error}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", s_ready, 1);
    s_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    s0 = strobes;
    run_frame(8'h03, 8'h05, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 8'h00);
    check("postrst_strobes", strobes - s0, 1);
    check("postrst_fd", last_fd, 32'hDEADBEEF);
    check("postrst_cs", last_cs, 16'h0008);

    // Reset asserted during STROBE drops the strobe without a clock edge.
    send_sync(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    send_byte(8'h24, 1'b0);
`endif
    tick();
    check("strobe_before_rst", FrameStrobe, 20'h00020);
    #1;
    resetn = 1'b0;
    #1;
    check("strobe_async_drop", FrameStrobe, 0);
    check("cs_async_drop", ColSelect, 0);
    tick();
    resetn = 1'b1;
    tick();

`ifdef CONFIG_FRAME_LOADER_CRC_EN
    s0 = strobes;
    run_frame(8'h03, 8'h05, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 8'h00);
    check("crc_good_strobes", strobes - s0, 1);
    check("crc_good_error", error, 0);
    s0 = strobes;
    run_frame(8'h03, 8'h05, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 8'h01);
    check("crc_bad_strobes", strobes - s0, 0);
    check("crc_bad_error", error, 1);
    pulse_clr();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1);
  end
endmodule
